// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_if
//  Description : MEM -> WB boundary bundle for the writeback stage. It carries
//                the pipeline controls, the MEM-stage fields and the
//                register-file write port produced by WB.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) ();
    // Pipeline control
    logic              stallW;
    logic              flushW;

    // MEM-stage fields
    logic              validM;
    logic [XLEN-1:0]   ALUResultM;
    logic [XLEN-1:0]   readDataM;
    logic [XLEN-1:0]   PCPlus4M;
    logic [XLEN-1:0]   immExtM;
    logic [1:0]        RES_SRC_M;
    logic [2:0]        funct3M;
    logic              RegWriteM;
    logic [REG_AW-1:0] RdM;

    // WB-stage results
    logic [XLEN-1:0]   resultW;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteW;
    logic              validW;
    logic [CNT_W-1:0]  retiredW;

    // Upstream side: drives MEM fields and controls, observes WB results
    modport master (
        output stallW, flushW, validM, ALUResultM, readDataM, PCPlus4M,
               immExtM, RES_SRC_M, funct3M, RegWriteM, RdM,
        input  resultW, RdW, RegWriteW, validW, retiredW
    );

    // Writeback stage side
    modport slave (
        input  stallW, flushW, validM, ALUResultM, readDataM, PCPlus4M,
               immExtM, RES_SRC_M, funct3M, RegWriteM, RdM,
        output resultW, RdW, RegWriteW, validW, retiredW
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : RV32/RV64 writeback stage. Registers the MEM/WB boundary
//                (stall/flush aware), extends and aligns load data, selects
//                the register-file write data and counts retired
//                instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   bus
);

    // Lane offset width within one XLEN word
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_PC4  = 2'b10;
    localparam logic [1:0] c_SRC_IMM  = 2'b11;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LD  = 3'b011;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_LWU = 3'b110;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // WB pipeline registers
    logic              r_valid;
    logic              r_regwrite;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_rdata;
    logic [XLEN-1:0]   r_pc4;
    logic [XLEN-1:0]   r_imm;
    logic [1:0]        r_src;
    logic [2:0]        r_f3;
    logic [REG_AW-1:0] r_rd;
    logic [CNT_W-1:0]  r_retired;

    // Load alignment / extension
    logic [OFF_W-1:0]  w_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_lb;
    logic [XLEN-1:0]   w_lbu;
    logic [XLEN-1:0]   w_lh;
    logic [XLEN-1:0]   w_lhu;
    logic [XLEN-1:0]   w_lw;
    logic [XLEN-1:0]   w_lwu;
    logic [XLEN-1:0]   w_ld;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_result;

    // MEM/WB boundary: reset > flush > stall > capture; the retire counter
    // advances only on an accepted valid instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
            r_src      <= '0;
            r_f3       <= '0;
            r_rd       <= '0;
            r_retired  <= '0;
        end else if (bus.flushW) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
            r_src      <= '0;
            r_f3       <= '0;
            r_rd       <= '0;
        end else if (!bus.stallW) begin
            r_valid    <= bus.validM;
            r_regwrite <= bus.RegWriteM;
            r_alu      <= bus.ALUResultM;
            r_rdata    <= bus.readDataM;
            r_pc4      <= bus.PCPlus4M;
            r_imm      <= bus.immExtM;
            r_src      <= bus.RES_SRC_M;
            r_f3       <= bus.funct3M;
            r_rd       <= bus.RdM;
            if (bus.validM) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    // Byte and halfword lanes; halfword offset ignores address bit 0
    assign w_off  = r_alu[OFF_W-1:0];
    assign w_byte = 8'(r_rdata >> {w_off, 3'b000});
    assign w_half = 16'(r_rdata >> {w_off[OFF_W-1:1], 4'b0000});

    assign w_lb  = {{(XLEN-8){w_byte[7]}}, w_byte};
    assign w_lbu = {{(XLEN-8){1'b0}}, w_byte};
    assign w_lh  = {{(XLEN-16){w_half[15]}}, w_half};
    assign w_lhu = {{(XLEN-16){1'b0}}, w_half};

    // Word / doubleword lanes depend on the datapath width
    generate
        if (XLEN == 64) begin : g_xlen64
            logic [31:0] w_word;
            assign w_word = w_off[2] ? r_rdata[63:32] : r_rdata[31:0];
            assign w_lw   = {{32{w_word[31]}}, w_word};
            assign w_lwu  = {32'b0, w_word};
            assign w_ld   = r_rdata;
        end else begin : g_xlen32
            // A full word needs no extension; LWU and LD fall back to LW
            assign w_lw  = r_rdata;
            assign w_lwu = r_rdata;
            assign w_ld  = r_rdata;
        end
    endgenerate

    // Load-type select; the unused funct3 encoding behaves as LW
    always_comb begin
        w_load = w_lw;
        case (r_f3)
            c_F3_LB:  w_load = w_lb;
            c_F3_LBU: w_load = w_lbu;
            c_F3_LH:  w_load = w_lh;
            c_F3_LHU: w_load = w_lhu;
            c_F3_LW:  w_load = w_lw;
            c_F3_LWU: w_load = w_lwu;
            c_F3_LD:  w_load = w_ld;
            default:  w_load = w_lw;
        endcase
    end

    // Result source select, purely from registered fields
    always_comb begin
        w_result = r_alu;
        case (r_src)
            c_SRC_ALU:  w_result = r_alu;
            c_SRC_LOAD: w_result = w_load;
            c_SRC_PC4:  w_result = r_pc4;
            c_SRC_IMM:  w_result = r_imm;
            default:    w_result = r_alu;
        endcase
    end

    assign bus.resultW   = w_result;
    assign bus.RdW       = r_rd;
    // x0 is hard-wired to zero, so writes to it are suppressed here
    assign bus.RegWriteW = r_regwrite & r_valid & (r_rd != '0);
    assign bus.validW    = r_valid;
    assign bus.retiredW  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage. Drives an RV32 instance
//                (32-bit counter) and an RV64 instance (4-bit counter) from
//                one stimulus set and compares both with a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Shared stimulus, 64-bit wide; the RV32 instance sees the low half
    logic        s_stall, s_flush, s_valid, s_rw;
    logic [63:0] s_alu, s_rdata, s_pc4, s_imm;
    logic [1:0]  s_src;
    logic [2:0]  s_f3;
    logic [4:0]  s_rd;

    wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) bus32 ();
    wb_stage_if #(.XLEN(64), .REG_AW(5), .CNT_W(4))  bus64 ();

    assign bus32.stallW     = s_stall;
    assign bus32.flushW     = s_flush;
    assign bus32.validM     = s_valid;
    assign bus32.ALUResultM = s_alu[31:0];
    assign bus32.readDataM  = s_rdata[31:0];
    assign bus32.PCPlus4M   = s_pc4[31:0];
    assign bus32.immExtM    = s_imm[31:0];
    assign bus32.RES_SRC_M  = s_src;
    assign bus32.funct3M    = s_f3;
    assign bus32.RegWriteM  = s_rw;
    assign bus32.RdM        = s_rd;

    assign bus64.stallW     = s_stall;
    assign bus64.flushW     = s_flush;
    assign bus64.validM     = s_valid;
    assign bus64.ALUResultM = s_alu;
    assign bus64.readDataM  = s_rdata;
    assign bus64.PCPlus4M   = s_pc4;
    assign bus64.immExtM    = s_imm;
    assign bus64.RES_SRC_M  = s_src;
    assign bus64.funct3M    = s_f3;
    assign bus64.RegWriteM  = s_rw;
    assign bus64.RdM        = s_rd;

    wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(32)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    wb_stage #(.XLEN(64), .REG_AW(5), .CNT_W(4)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view of what WB holds
    typedef struct {
        logic        valid;
        logic        rw;
        logic [63:0] alu, rdata, pc4, imm;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] cnt;
    } wb_model_t;

    wb_model_t m32, m64;

    function automatic logic [63:0] xmask(int xlen);
        return (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Load value from the RISC-V load rules, using plain arithmetic
    function automatic logic [63:0] ref_load(int xlen, logic [2:0] f3,
                                             logic [63:0] addr, logic [63:0] data);
        int          off;
        int          wsel;
        logic [63:0] v;
        off = (xlen == 64) ? int'(addr % 8) : int'(addr % 4);
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (data >> (8 * off)) & 64'hFF;
            if (f3 == 3'd0 && v[7]) v = v | ~64'hFF;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (data >> (8 * (off - (off % 2)))) & 64'hFFFF;
            if (f3 == 3'd1 && v[15]) v = v | ~64'hFFFF;
        end else if (xlen == 64 && f3 == 3'd3) begin
            v = data;
        end else begin
            wsel = (xlen == 64 && off >= 4) ? 32 : 0;
            v = (data >> wsel) & 64'hFFFF_FFFF;
            if (!(xlen == 64 && f3 == 3'd6) && v[31]) v = v | ~64'hFFFF_FFFF;
        end
        return v & xmask(xlen);
    endfunction

    function automatic logic [63:0] ref_result(int xlen, wb_model_t m);
        case (m.src)
            2'd0:    return m.alu;
            2'd1:    return ref_load(xlen, m.f3, m.alu, m.rdata);
            2'd2:    return m.pc4;
            default: return m.imm;
        endcase
    endfunction

    function automatic logic ref_regwrite(wb_model_t m);
        return m.valid && m.rw && (m.rd != 5'd0);
    endfunction

    // Next architectural WB contents given the stimulus present before the edge
    function automatic wb_model_t model_step(wb_model_t m, int xlen, int cnt_w);
        wb_model_t   n;
        logic [63:0] mk;
        n  = m;
        mk = xmask(xlen);
        if (reset) begin
            n = '{valid: 1'b0, rw: 1'b0, alu: 64'd0, rdata: 64'd0, pc4: 64'd0,
                  imm: 64'd0, src: 2'd0, f3: 3'd0, rd: 5'd0, cnt: 64'd0};
        end else if (s_flush) begin
            n = '{valid: 1'b0, rw: 1'b0, alu: 64'd0, rdata: 64'd0, pc4: 64'd0,
                  imm: 64'd0, src: 2'd0, f3: 3'd0, rd: 5'd0, cnt: m.cnt};
        end else if (!s_stall) begin
            n.valid = s_valid;
            n.rw    = s_rw;
            n.alu   = s_alu & mk;
            n.rdata = s_rdata & mk;
            n.pc4   = s_pc4 & mk;
            n.imm   = s_imm & mk;
            n.src   = s_src;
            n.f3    = s_f3;
            n.rd    = s_rd;
            if (s_valid) n.cnt = (m.cnt + 64'd1) % (64'd1 << cnt_w);
        end
        return n;
    endfunction

    // Advance one clock, keeping the model in lockstep, and settle past the edge
    task automatic step();
        m32 = model_step(m32, 32, 32);
        m64 = model_step(m64, 64, 4);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_stall = 0; s_flush = 0; s_valid = 0; s_rw = 0;
        s_alu = 0; s_rdata = 0; s_pc4 = 0; s_imm = 0;
        s_src = 0; s_f3 = 0; s_rd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; s_valid = 1; s_rw = 1; s_rd = 5'd5;
        s_alu = 64'h1234; s_imm = 64'h55;
        step(); step();
        n_tests++; if (bus32.validW !== 1'b0) begin n_fail++; $display("FAIL reset_validW: got %b expected 0", bus32.validW); end
        n_tests++; if (bus32.RegWriteW !== 1'b0) begin n_fail++; $display("FAIL reset_RegWriteW: got %b expected 0", bus32.RegWriteW); end
        n_tests++; if (bus32.RdW !== 5'd0) begin n_fail++; $display("FAIL reset_RdW: got %0d expected 0", bus32.RdW); end
        n_tests++; if (bus32.resultW !== 32'd0) begin n_fail++; $display("FAIL reset_resultW: got %h expected 0", bus32.resultW); end
        n_tests++; if (bus32.retiredW !== 32'd0) begin n_fail++; $display("FAIL reset_retiredW: got %0d expected 0", bus32.retiredW); end
        n_tests++; if (bus64.retiredW !== 4'd0) begin n_fail++; $display("FAIL reset_retiredW64: got %0d expected 0", bus64.retiredW); end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_sources();
        logic [1:0]  srcs [3] = '{2'b00, 2'b10, 2'b11};
        logic [31:0] exps [3] = '{32'h10, 32'h104, 32'hABCD_0000};
        idle_inputs();
        s_valid = 1; s_rw = 1; s_rd = 5'd3;
        s_alu = 64'h10; s_imm = 64'hABCD_0000; s_pc4 = 64'h104;
        for (int i = 0; i < 3; i++) begin
            s_src = srcs[i];
            step();
            n_tests++; if (bus32.resultW !== exps[i]) begin n_fail++; $display("FAIL source_%0d resultW: got %h expected %h", srcs[i], bus32.resultW, exps[i]); end
            n_tests++; if (bus32.RegWriteW !== 1'b1 || bus32.RdW !== 5'd3) begin n_fail++; $display("FAIL source_%0d write port: got we=%b rd=%0d expected we=1 rd=3", srcs[i], bus32.RegWriteW, bus32.RdW); end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [63:0] offs [5] = '{64'd3, 64'd3, 64'd2, 64'd0, 64'd0};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                  32'h0000_7F01, 32'h80FF_7F01};
        idle_inputs();
        s_valid = 1; s_rw = 1; s_rd = 5'd9; s_src = 2'b01;
        s_rdata = 64'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            s_f3  = f3s[i];
            s_alu = 64'h1000 + offs[i];
            step();
            n_tests++; if (bus32.resultW !== exps[i]) begin n_fail++; $display("FAIL load_f3_%0d_off%0d: got %h expected %h", f3s[i], offs[i], bus32.resultW, exps[i]); end
        end
    endtask

    task automatic test_x0();
        logic [31:0] exp_cnt;
        idle_inputs();
        s_valid = 1; s_rw = 1; s_rd = 5'd0; s_alu = 64'h77;
        exp_cnt = m32.cnt[31:0] + 32'd1;
        step();
        n_tests++; if (bus32.RegWriteW !== 1'b0) begin n_fail++; $display("FAIL x0_RegWriteW: got %b expected 0", bus32.RegWriteW); end
        n_tests++; if (bus32.validW !== 1'b1) begin n_fail++; $display("FAIL x0_validW: got %b expected 1", bus32.validW); end
        n_tests++; if (bus32.retiredW !== exp_cnt) begin n_fail++; $display("FAIL x0_retiredW: got %0d expected %0d", bus32.retiredW, exp_cnt); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] held_cnt;
        idle_inputs();
        s_valid = 1; s_rw = 1; s_rd = 5'd7; s_alu = 64'h55; s_src = 2'b00;
        step();
        held_cnt = m32.cnt[31:0];
        s_stall = 1;
        for (int i = 0; i < 3; i++) begin
            s_alu = {$urandom, $urandom}; s_rd = 5'($urandom_range(1, 31));
            s_src = 2'($urandom); s_valid = 1;
            step();
            n_tests++; if (bus32.resultW !== 32'h55 || bus32.RdW !== 5'd7 || bus32.RegWriteW !== 1'b1 || bus32.validW !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold_%0d: got res=%h rd=%0d we=%b v=%b expected res=55 rd=7 we=1 v=1", i, bus32.resultW, bus32.RdW, bus32.RegWriteW, bus32.validW); end
            n_tests++; if (bus32.retiredW !== held_cnt) begin n_fail++; $display("FAIL stall_count_%0d: got %0d expected %0d", i, bus32.retiredW, held_cnt); end
        end
        s_flush = 1; s_valid = 1; s_rw = 1; s_rd = 5'd4;
        step();
        n_tests++; if (bus32.validW !== 1'b0 || bus32.RegWriteW !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall: got v=%b we=%b expected 0 0", bus32.validW, bus32.RegWriteW); end
        n_tests++; if (bus32.retiredW !== held_cnt) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", bus32.retiredW, held_cnt); end
        n_tests++; if (bus32.resultW !== 32'd0 || bus32.RdW !== 5'd0) begin n_fail++; $display("FAIL flush_zero: got res=%h rd=%0d expected 0 0", bus32.resultW, bus32.RdW); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        s_valid = 1; s_rw = 1; s_rd = 5'd1;
        for (int i = 0; i < 17; i++) step();
        n_tests++; if (bus64.retiredW !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt4: got %0d expected 1", bus64.retiredW); end
        n_tests++; if (bus32.retiredW !== 32'd17) begin n_fail++; $display("FAIL wrap_cnt32: got %0d expected 17", bus32.retiredW); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [63:0] e32, e64;
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 49) == 0);
            s_stall = ($urandom_range(0, 4) == 0);
            s_flush = ($urandom_range(0, 7) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_rw    = ($urandom_range(0, 3) != 0);
            s_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            s_alu   = {$urandom, $urandom};
            s_rdata = {$urandom, $urandom};
            s_pc4   = {$urandom, $urandom};
            s_imm   = {$urandom, $urandom};
            s_src   = 2'($urandom);
            s_f3    = 3'($urandom);
            step();
            e32 = ref_result(32, m32);
            e64 = ref_result(64, m64);
            n_tests++; if ({32'd0, bus32.resultW} !== e32 || bus32.RdW !== m32.rd || bus32.RegWriteW !== ref_regwrite(m32) || bus32.validW !== m32.valid) begin
                n_fail++; $display("FAIL rand32_%0d outputs: got res=%h rd=%0d we=%b v=%b expected res=%h rd=%0d we=%b v=%b", i, bus32.resultW, bus32.RdW, bus32.RegWriteW, bus32.validW, e32[31:0], m32.rd, ref_regwrite(m32), m32.valid); end
            n_tests++; if (bus32.retiredW !== m32.cnt[31:0]) begin n_fail++; $display("FAIL rand32_%0d retired: got %0d expected %0d", i, bus32.retiredW, m32.cnt[31:0]); end
            n_tests++; if (bus64.resultW !== e64 || bus64.RdW !== m64.rd || bus64.RegWriteW !== ref_regwrite(m64) || bus64.validW !== m64.valid) begin
                n_fail++; $display("FAIL rand64_%0d outputs: got res=%h rd=%0d we=%b v=%b expected res=%h rd=%0d we=%b v=%b", i, bus64.resultW, bus64.RdW, bus64.RegWriteW, bus64.validW, e64, m64.rd, ref_regwrite(m64), m64.valid); end
            n_tests++; if (bus64.retiredW !== m64.cnt[3:0]) begin n_fail++; $display("FAIL rand64_%0d retired: got %0d expected %0d", i, bus64.retiredW, m64.cnt[3:0]); end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        m32 = '{valid: 1'b0, rw: 1'b0, alu: 64'd0, rdata: 64'd0, pc4: 64'd0,
                imm: 64'd0, src: 2'd0, f3: 3'd0, rd: 5'd0, cnt: 64'd0};
        m64 = m32;
        test_reset();
        test_sources();
        test_loads();
        test_x0();
        test_stall_flush();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised writeback stage for the RV32/RV64 pipeline, successor to the combinational writeback result select.
- Registers the MEM/WB pipeline boundary with stall and flush.
- Extends and aligns load data, then selects among four result sources.
- Produces the register-file write port and a retired-instruction counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
REG_AW, 5, register-file address width
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stallW  input  1  hold all WB registers
flushW  input  1  squash the instruction entering WB
validM  input  1  instruction in MEM is valid
ALUResultM  input  XLEN  ALU result / load address
readDataM  input  XLEN  raw (unaligned-lane) data memory read word
PCPlus4M  input  XLEN  PC+4 of MEM instruction
immExtM  input  XLEN  extended immediate (LUI)
RES_SRC_M  input  2  result source select
funct3M  input  3  load type
RegWriteM  input  1  instruction writes rd
RdM  input  REG_AW  destination register
resultW  output  XLEN  register-file write data
RdW  output  REG_AW  register-file write address
RegWriteW  output  1  effective register-file write enable
validW  output  1  WB holds a valid instruction
retiredW  output  CNT_W  count of instructions accepted into WB

Behaviour:
- Pipeline register update (priority order, evaluated at each clk edge):
  1. reset: all WB registers, including validW and retiredW, become 0.
  2. flushW: valid_q and regwrite_q become 0 and the other fields are zeroed; flushW overrides stallW.
  3. stallW: all registers hold their values.
  4. Otherwise: capture validM, ALUResultM, readDataM, PCPlus4M, immExtM, RES_SRC_M, funct3M, RegWriteM and RdM.
- Latency: one cycle from the MEM inputs to the WB outputs. resultW is combinational from the registered fields.
- Result select:
  - 00: ALUResult
  - 01: load data after extension
  - 10: PCPlus4
  - 11: immExt
- Load extension:
  - Lane offset is ALUResult[1:0] for XLEN=32 and ALUResult[2:0] for XLEN=64.
  - funct3 000 LB: byte at offset, sign-extended.
  - funct3 100 LBU: byte at offset, zero-extended.
  - funct3 001 LH: halfword at offset with bit 0 ignored, sign-extended.
  - funct3 101 LHU: same halfword, zero-extended.
  - funct3 010 LW: word (for XLEN=64, word selected by bit 2), sign-extended.
  - funct3 110 LWU: same word, zero-extended; for XLEN=32 it behaves as LW.
  - funct3 011 LD: full doubleword for XLEN=64; for XLEN=32 it behaves as LW.
  - funct3 111: behaves as LW.
- RegWriteW = regwrite_q & valid_q & (RdW != 0).
  - x0 is never written.
  - resultW and RdW are still driven when RegWriteW=0.
- validW = valid_q.
- retiredW increments by 1 on every edge where validM & ~stallW & ~flushW & ~reset. It wraps from 2^CNT_W-1 to 0.
- Reset mid-stall or mid-flush: reset wins and clears everything, including the counter.
- No combinational path from any M-stage input to any output.

Test Plan:
- Reset: hold reset for 2 cycles with validM=1 and RdM=5 -> validW=0, RegWriteW=0, RdW=0, resultW=0, retiredW=0.
- Sources: XLEN=32, ALUResultM=0x10, immExtM=0xABCD0000, PCPlus4M=0x104, RES_SRC_M stepped through 00/10/11 with RegWriteM=1 and RdM=3 -> next cycle resultW = 0x10, 0x104, 0xABCD0000 respectively, RegWriteW=1.
- Loads: readDataM=0x80FF7F01, RES_SRC_M=01.
  - LB at offset 3 -> 0xFFFFFF80.
  - LBU at offset 3 -> 0x00000080.
  - LH at offset 2 -> 0xFFFF80FF.
  - LHU at offset 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- x0 guard: RdM=0, RegWriteM=1, validM=1 -> RegWriteW=0, validW=1, retiredW increments.
- Stall/flush: capture an instruction, then assert stallW for 3 cycles with changing M inputs -> WB outputs frozen and retiredW unchanged. Assert stallW and flushW together -> validW=0, RegWriteW=0, no increment.
- Counter wrap: CNT_W=4, feed 17 valid unstalled instructions -> retiredW reads 1.
